wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file.
- Merges two result sources into the register file's single write port:
  - the single-cycle integer (ALU/load) path;
  - a multi-cycle mul/div unit using a valid/ready handshake.
- Holds a pending-destination scoreboard that stalls decode on RAW/WAW hazards against in-flight mul/div results.
- Drives the register file's reg_write, rd_addr and wr_data from registers.

Parameters:
- WIDTH, 32, data width of results and of wr_data.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-low.
- alu_valid  in  1  single-cycle result valid this cycle.
- alu_rd  in  5  destination of the ALU result.
- alu_data  in  WIDTH  ALU result.
- md_issue  in  1  mul/div launched this cycle; marks md_issue_rd pending.
- md_issue_rd  in  5  destination of the launched mul/div.
- md_valid  in  1  mul/div result valid.
- md_rd  in  5  mul/div result destination.
- md_data  in  WIDTH  mul/div result.
- md_ready  out  1  block accepts the mul/div result this cycle.
- dec_rs1  in  5  decode source 1 address.
- dec_rs2  in  5  decode source 2 address.
- dec_rd  in  5  decode destination address.
- stall  out  1  decode must hold (combinational).
- pending  out  32  scoreboard bitmap; bit 0 is always 0.
- reg_write  out  1  register file write enable (registered).
- rd_addr  out  5  register file write address (registered).
- wr_data  out  WIDTH  register file write data (registered).

Behaviour:
- Reset: synchronous, active-low, sampled on the rising clk edge.
  - Clears reg_write, rd_addr, wr_data, the skid buffer valid flag and all pending bits.
  - md_ready is 0 while reset is low.
  - Reset mid-operation discards any buffered md result and all pending state. No partial write is emitted.
- Skid buffer:
  - One entry: buf_valid, buf_rd, buf_data.
  - md_ready = reset & (!buf_valid | !alu_valid).
  - Handshake completes when md_valid & md_ready at an edge. The result goes into the buffer.
  - The producer holds md_rd/md_data stable while md_valid & !md_ready.
- Arbitration, evaluated each cycle; the output registers load at the edge:
  - If alu_valid & alu_rd!=0: emit the ALU result. The buffer keeps its entry.
  - Else if buf_valid: emit the buffer and clear buf_valid. The same edge can refill the buffer from md, giving back-to-back md at one per cycle when the ALU is idle.
  - Else: reg_write=0 and rd_addr/wr_data hold their previous values.
- ALU priority:
  - ALU always has priority.
  - Starvation of md is bounded by decode stalling on the pending rd.
- x0 handling:
  - alu_rd==0 and md_rd==0 results are never emitted (reg_write stays 0). An md result to rd 0 is still consumed.
  - md_issue with md_issue_rd==0 sets no pending bit.
- Latency: 1 cycle from accept/select to reg_write=1. The register file latches at the following edge.
- Scoreboard:
  - pending[md_issue_rd] is set at the edge where md_issue=1.
  - pending[r] is cleared at the edge where reg_write=1, rd_addr=r and the output register holds an md-sourced write. A source flag is kept in the output register.
  - Set and clear of the same index at the same edge: set wins.
- stall = pending[dec_rs1] | pending[dec_rs2] | pending[dec_rd], with index 0 ignored.
- Illegal conditions, flagged by bench assertions:
  - ALU write to a pending rd.
  - md_issue to a pending rd.
  - md_valid for an rd that is not pending.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Adds outputs rs1_fwd and rs2_fwd (1 bit each).
  - rsX_fwd = reg_write & rd_addr==dec_rsX & dec_rsX!=0. Decode then muxes wr_data in place of register file read data.
  - stall ignores the pending bit of a source whose rsX_fwd=1 in the same cycle. This removes one stall cycle per md result.
- Undefined:
  - The ports are absent.
  - stall is exactly as above; decode waits until the register file is written.

Test Plan:
- Reset held low 2 cycles with md_valid=1 -> md_ready=0, reg_write=0, pending=0. After release, md_ready=1 in the first cycle.
- alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> next cycle reg_write=1, rd_addr=5, wr_data=0xDEADBEEF. alu_rd=0 -> reg_write stays 0.
- md_issue rd=7, then dec_rs1=7 -> stall=1 until the edge where the md write of 0x12345678 to r7 retires. stall=0 the next cycle; with WB_BYPASS_EN, rs1_fwd=1 and stall=0 in the retire cycle.
- alu_valid and md_valid in the same cycle, buffer empty -> md accepted into buffer, ALU written first. The md result is written the next cycle if alu_valid=0.
- Buffer full with alu_valid=1 for 3 cycles -> md_ready=0 for 3 cycles, md held. The buffer drains on the first ALU-idle cycle and the new md is accepted on that same edge.
- md_issue rd=9 and retire of rd=9 at the same edge -> pending[9] remains 1. Reset asserted while the buffer is full -> no write emitted and pending cleared.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback stage in front of the register file write port.
// Merges the single-cycle ALU path with a valid/ready mul/div path through a
// one-entry skid buffer, and keeps a pending-destination scoreboard that
// stalls decode on hazards against in-flight mul/div results.
// Optional feature macro: WB_BYPASS_EN adds rs1_fwd/rs2_fwd forwarding hints
// and lets a forwarded source skip its pending-bit stall.
module wb_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             md_issue,
  input  logic [4:0]       md_issue_rd,
  input  logic             md_valid,
  input  logic [4:0]       md_rd,
  input  logic [WIDTH-1:0] md_data,
  output logic             md_ready,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic [4:0]       dec_rd,
`ifdef WB_BYPASS_EN
  output logic             rs1_fwd,
  output logic             rs2_fwd,
`endif
  output logic             stall,
  output logic [31:0]      pending,
  output logic             reg_write,
  output logic [4:0]       rd_addr,
  output logic [WIDTH-1:0] wr_data
);

  logic             buf_valid_q, buf_valid_d;
  logic [4:0]       buf_rd_q, buf_rd_d;
  logic [WIDTH-1:0] buf_data_q, buf_data_d;
  logic             reg_write_q, reg_write_d;
  logic             src_md_q, src_md_d;
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [31:0]      pending_q, pending_d;
  logic             alu_sel, buf_sel, md_acc;
  logic             s1_hit, s2_hit;

  // Buffer can take a result if it is empty or will drain this cycle
  // (it always drains when the ALU is idle).
  always_comb begin
    md_ready = reset & (~buf_valid_q | ~alu_valid);
    md_acc   = md_valid & md_ready;
    alu_sel  = alu_valid & (alu_rd != 5'd0);
    buf_sel  = ~alu_sel & buf_valid_q;
  end

  // Next-state for output register, skid buffer and scoreboard.
  always_comb begin
    reg_write_d = 1'b0;
    src_md_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    wr_data_d   = wr_data_q;
    if (alu_sel) begin
      reg_write_d = 1'b1;
      rd_addr_d   = alu_rd;
      wr_data_d   = alu_data;
    end else if (buf_sel && buf_rd_q != 5'd0) begin
      // x0 entries are drained silently; address/data hold.
      reg_write_d = 1'b1;
      src_md_d    = 1'b1;
      rd_addr_d   = buf_rd_q;
      wr_data_d   = buf_data_q;
    end

    buf_valid_d = buf_valid_q & ~buf_sel;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
    if (md_acc) begin
      buf_valid_d = 1'b1;
      buf_rd_d    = md_rd;
      buf_data_d  = md_data;
    end

    // Clear first so a same-edge re-issue of the retiring rd wins.
    pending_d = pending_q;
    if (reg_write_q && src_md_q) pending_d[rd_addr_q] = 1'b0;
    if (md_issue && md_issue_rd != 5'd0) pending_d[md_issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_valid_q <= 1'b0;
      buf_rd_q    <= '0;
      buf_data_q  <= '0;
      reg_write_q <= 1'b0;
      src_md_q    <= 1'b0;
      rd_addr_q   <= '0;
      wr_data_q   <= '0;
      pending_q   <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_rd_q    <= buf_rd_d;
      buf_data_q  <= buf_data_d;
      reg_write_q <= reg_write_d;
      src_md_q    <= src_md_d;
      rd_addr_q   <= rd_addr_d;
      wr_data_q   <= wr_data_d;
      pending_q   <= pending_d;
    end
  end

  // Decode hazard check against the scoreboard.
  always_comb begin
    s1_hit = (dec_rs1 != 5'd0) & pending_q[dec_rs1];
    s2_hit = (dec_rs2 != 5'd0) & pending_q[dec_rs2];
`ifdef WB_BYPASS_EN
    rs1_fwd = reg_write_q & (rd_addr_q == dec_rs1) & (dec_rs1 != 5'd0);
    rs2_fwd = reg_write_q & (rd_addr_q == dec_rs2) & (dec_rs2 != 5'd0);
    // A source being written this cycle is forwarded, not waited on.
    s1_hit  = s1_hit & ~rs1_fwd;
    s2_hit  = s2_hit & ~rs2_fwd;
`endif
    stall = s1_hit | s2_hit | ((dec_rd != 5'd0) & pending_q[dec_rd]);
  end

  assign pending   = pending_q;
  assign reg_write = reg_write_q;
  assign rd_addr   = rd_addr_q;
  assign wr_data   = wr_data_q;

endmodule
